// File: rtl/sweep_pkg.sv
// Shared definitions for the FCW sweep controller and the NCO wrapper that consumes fcw_out.
package sweep_pkg;
   localparam int FCW_W_DEF   = 16;
   localparam int DWELL_W_DEF = 24;

   localparam logic MODE_SINGLE = 1'b0;
   localparam logic MODE_TRI    = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2
   } sweep_state_t;
endpackage

// File: rtl/fcw_sweep_ctrl_dwell_timer.sv
// Down-counter holding each FCW value; expire is high whenever the count has run out.
module dwell_timer
   import sweep_pkg::*;
#(
   parameter int DWELL_W = DWELL_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [DWELL_W-1:0] load_val,
   output logic               expire
);

   logic [DWELL_W-1:0] cnt_r;

   // Count register: reload on every new FCW, otherwise count down and stop at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= '0;
      end else if (load) begin
         cnt_r <= load_val;
      end else if (cnt_r != '0) begin
         cnt_r <= cnt_r - DWELL_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign expire = (cnt_r == '0);

endmodule

// File: rtl/fcw_sweep_ctrl.sv
// Programmable stepped FCW sweep (single up-ramp or continuous triangle) feeding the NCO phase increment.
module fcw_sweep_ctrl
   import sweep_pkg::*;
#(
   parameter int FCW_W   = FCW_W_DEF,
   parameter int DWELL_W = DWELL_W_DEF
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   input  logic               start,
   input  logic               abort,
   input  logic               mode,
   input  logic [FCW_W-1:0]   fcw_start,
   input  logic [FCW_W-1:0]   fcw_stop,
   input  logic [FCW_W-1:0]   fcw_step,
   input  logic [DWELL_W-1:0] dwell,
   output logic [FCW_W-1:0]   fcw_out,
   output logic               fcw_valid,
   output logic               busy,
   output logic               done
);

   function automatic logic [FCW_W-1:0] step_at_least_one(input logic [FCW_W-1:0] v);
      return (v == '0) ? FCW_W'(1) : v;
   endfunction

   function automatic logic [DWELL_W-1:0] dwell_minus_one(input logic [DWELL_W-1:0] v);
      return (v == '0) ? '0 : v - DWELL_W'(1);
   endfunction

   sweep_state_t       state_r, nxt_state_s;
   logic               mode_r, degen_r;
   logic [FCW_W-1:0]   lo_r, hi_r, step_r;
   logic [DWELL_W-1:0] dwell_m1_r, load_val_s;
   logic [FCW_W:0]     up_sum_s, dn_dif_s;
   logic [FCW_W-1:0]   up_nxt_s, dn_nxt_s, nxt_fcw_s;
   logic               go_s, load_s, finish_s, expire_s;

   // Next up/down values, clamped to the latched bounds; carry/borrow is the extra MSB.
   always_comb begin
      up_sum_s = {1'b0, fcw_out} + {1'b0, step_r};
      dn_dif_s = {1'b0, fcw_out} - {1'b0, step_r};
      if (up_sum_s[FCW_W] || (up_sum_s[FCW_W-1:0] >= hi_r)) begin
         up_nxt_s = hi_r;
      end else begin
         up_nxt_s = up_sum_s[FCW_W-1:0];
      end
      if (dn_dif_s[FCW_W] || (dn_dif_s[FCW_W-1:0] <= lo_r)) begin
         dn_nxt_s = lo_r;
      end else begin
         dn_nxt_s = dn_dif_s[FCW_W-1:0];
      end
   end

   // Sweep decisions: abort beats everything, a step fires only when the dwell has expired.
   always_comb begin
      go_s        = (state_r == IDLE) && start && !abort;
      load_s      = 1'b0;
      finish_s    = 1'b0;
      nxt_state_s = state_r;
      nxt_fcw_s   = fcw_out;
      case (state_r)
         IDLE: begin
            if (go_s) begin
               load_s      = 1'b1;
               nxt_fcw_s   = fcw_start;
               nxt_state_s = UP;
            end else begin
               nxt_state_s = IDLE;
            end
         end
         UP: begin
            if (abort) begin
               nxt_state_s = IDLE;
            end else if (!expire_s) begin
               nxt_state_s = UP;
            end else if (degen_r || ((fcw_out == hi_r) && (mode_r == MODE_SINGLE))) begin
               finish_s    = 1'b1;
               nxt_state_s = IDLE;
            end else if (fcw_out == hi_r) begin
               load_s      = 1'b1;
               nxt_fcw_s   = dn_nxt_s;
               nxt_state_s = DOWN;
            end else begin
               load_s      = 1'b1;
               nxt_fcw_s   = up_nxt_s;
            end
         end
         DOWN: begin
            if (abort) begin
               nxt_state_s = IDLE;
            end else if (!expire_s) begin
               nxt_state_s = DOWN;
            end else if (fcw_out == lo_r) begin
               load_s      = 1'b1;
               nxt_fcw_s   = up_nxt_s;
               nxt_state_s = UP;
            end else begin
               load_s      = 1'b1;
               nxt_fcw_s   = dn_nxt_s;
            end
         end
         default: begin
            nxt_state_s = IDLE;
         end
      endcase
      if (state_r == IDLE) begin
         load_val_s = dwell_minus_one(dwell);
      end else begin
         load_val_s = dwell_m1_r;
      end
   end

   // State, registered outputs and the configuration captured when a sweep starts.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_r    <= IDLE;
         fcw_out    <= '0;
         fcw_valid  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         mode_r     <= MODE_SINGLE;
         degen_r    <= 1'b0;
         lo_r       <= '0;
         hi_r       <= '0;
         step_r     <= FCW_W'(1);
         dwell_m1_r <= '0;
      end else begin
         state_r   <= nxt_state_s;
         fcw_out   <= nxt_fcw_s;
         fcw_valid <= load_s;
         busy      <= (nxt_state_s != IDLE);
         done      <= finish_s;
         if (go_s) begin
            mode_r     <= mode;
            degen_r    <= (fcw_stop <= fcw_start);
            lo_r       <= fcw_start;
            hi_r       <= fcw_stop;
            step_r     <= step_at_least_one(fcw_step);
            dwell_m1_r <= dwell_minus_one(dwell);
         end
      end
   end

   dwell_timer #(.DWELL_W(DWELL_W)) u_dwell_timer (
      .clk      (sys_clk),
      .rst      (sys_rst),
      .load     (load_s),
      .load_val (load_val_s),
      .expire   (expire_s)
   );

endmodule

// File: tb/tb_fcw_sweep_ctrl.sv
// Self-checking bench for fcw_sweep_ctrl: vector table with scoreboard queue plus abort/reset sequences.
module tb_fcw_sweep_ctrl;
   localparam int W  = 16;
   localparam int DW = 24;

   logic          sys_clk = 1'b0;
   logic          sys_rst, start, abort, mode;
   logic [W-1:0]  fcw_start, fcw_stop, fcw_step;
   logic [DW-1:0] dwell;
   logic [W-1:0]  fcw_out;
   logic          fcw_valid, busy, done;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic          m;
      logic [W-1:0]  lo, hi, st;
      logic [DW-1:0] dw;
      logic [3:0]    n;
      logic          fin;
      logic [7:0][W-1:0] v;
   } vec_t;

   typedef struct packed {
      logic [W-1:0]  f;
      logic [31:0]   off;
   } exp_t;

   vec_t tbl [8];
   exp_t exp_q [$];

   fcw_sweep_ctrl #(.FCW_W(W), .DWELL_W(DW)) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .start     (start),
      .abort     (abort),
      .mode      (mode),
      .fcw_start (fcw_start),
      .fcw_stop  (fcw_stop),
      .fcw_step  (fcw_step),
      .dwell     (dwell),
      .fcw_out   (fcw_out),
      .fcw_valid (fcw_valid),
      .busy      (busy),
      .done      (done)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input int m, input int lo, input int hi, input int st, input int dw,
                               input int n, input int fin, input int a0, input int a1, input int a2,
                               input int a3, input int a4, input int a5, input int a6, input int a7);
      vec_t r;
      r.m = m[0]; r.lo = W'(lo); r.hi = W'(hi); r.st = W'(st); r.dw = DW'(dw);
      r.n = 4'(n); r.fin = fin[0];
      r.v[0] = W'(a0); r.v[1] = W'(a1); r.v[2] = W'(a2); r.v[3] = W'(a3);
      r.v[4] = W'(a4); r.v[5] = W'(a5); r.v[6] = W'(a6); r.v[7] = W'(a7);
      return r;
   endfunction

   task automatic wait_idle();
      for (int i = 0; i < 64 && busy; i++) tick();
      chk("idle_timeout", int'(busy), 0);
   endtask

   task automatic drive_cfg(input logic m, input int lo, input int hi, input int st, input int dw);
      mode = m; fcw_start = W'(lo); fcw_stop = W'(hi); fcw_step = W'(st); dwell = DW'(dw);
   endtask

   task automatic run_vec(input int idx);
      vec_t t;
      exp_t e;
      int d, don, len;
      bit have;
      logic [W-1:0] cur;
      t = tbl[idx];
      d = (t.dw == '0) ? 1 : int'(t.dw);
      don = 1 + int'(t.n) * d;
      len = t.fin ? don + 2 : int'(t.n) * d;
      have = 1'b0;
      cur = '0;
      wait_idle();
      drive_cfg(t.m, int'(t.lo), int'(t.hi), int'(t.st), int'(t.dw));
      start = 1'b1;
      for (int j = 0; j < int'(t.n); j++) begin
         e.f = t.v[j];
         e.off = 32'(1 + j * d);
         exp_q.push_back(e);
      end
      for (int k = 1; k <= len; k++) begin
         tick();
         if (k == 1) start = 1'b0;
         if (k == 2 && don > 3) begin
            start = 1'b1;
            drive_cfg(~t.m, 0, 0, 7, 9);
         end
         if (k == 3) start = 1'b0;
         if (fcw_valid) begin
            if (exp_q.size() == 0) begin
               chk("extra_valid", int'(fcw_valid), 0);
            end else begin
               e = exp_q.pop_front();
               chk("valid_offset", k, int'(e.off));
               chk("valid_fcw", int'(fcw_out), int'(e.f));
               have = 1'b1;
               cur = e.f;
            end
         end else if (have) begin
            chk("hold_fcw", int'(fcw_out), int'(cur));
         end
         chk("done", int'(done), (t.fin && k == don) ? 1 : 0);
         chk("busy", int'(busy), (!t.fin || k < don) ? 1 : 0);
      end
      chk("queue_empty", exp_q.size(), 0);
      exp_q.delete();
      start = 1'b0;
      if (!t.fin) begin
         abort = 1'b1;
         tick();
         abort = 1'b0;
         chk("tri_abort_busy", int'(busy), 0);
      end
   endtask

   initial begin
      tbl[0] = mk(0, 1000, 1400, 100, 4, 5, 1, 1000, 1100, 1200, 1300, 1400, 0, 0, 0);
      tbl[1] = mk(0, 1000, 1250, 100, 2, 4, 1, 1000, 1100, 1200, 1250, 0, 0, 0, 0);
      tbl[2] = mk(1, 100, 300, 100, 1, 8, 0, 100, 200, 300, 200, 100, 200, 300, 200);
      tbl[3] = mk(0, 65000, 65535, 1000, 3, 2, 1, 65000, 65535, 0, 0, 0, 0, 0, 0);
      tbl[4] = mk(1, 65000, 65535, 1000, 1, 5, 0, 65000, 65535, 65000, 65535, 65000, 0, 0, 0);
      tbl[5] = mk(0, 10, 13, 0, 0, 4, 1, 10, 11, 12, 13, 0, 0, 0, 0);
      tbl[6] = mk(0, 10, 5, 100, 0, 1, 1, 10, 0, 0, 0, 0, 0, 0, 0);
      tbl[7] = mk(1, 10, 10, 3, 2, 1, 1, 10, 0, 0, 0, 0, 0, 0, 0);

      sys_rst = 1'b1; start = 1'b0; abort = 1'b0;
      drive_cfg(1'b0, 0, 0, 0, 0);
      tick();
      tick();
      chk("rst_fcw", int'(fcw_out), 0);
      chk("rst_valid", int'(fcw_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      sys_rst = 1'b0;
      tick();

      for (int i = 0; i < 8; i++) run_vec(i);

      // Abort during the 1200 dwell, with a start attempt while busy.
      wait_idle();
      drive_cfg(1'b0, 1000, 1400, 100, 4);
      start = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (k == 1) start = 1'b0;
         if (k == 6) begin start = 1'b1; fcw_start = W'(5); end
         if (k == 7) start = 1'b0;
         if (k == 9) chk("abort_pre_fcw", int'(fcw_out), 1200);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_fcw", int'(fcw_out), 1200);
      chk("abort_valid", int'(fcw_valid), 0);
      chk("abort_done", int'(done), 0);
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("post_abort_done", int'(done), 0);
         chk("post_abort_valid", int'(fcw_valid), 0);
         chk("post_abort_fcw", int'(fcw_out), 1200);
      end

      // Start and abort together in IDLE.
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      chk("sa_busy", int'(busy), 0);
      chk("sa_valid", int'(fcw_valid), 0);
      chk("sa_fcw", int'(fcw_out), 1200);
      tick();
      chk("sa_busy2", int'(busy), 0);

      // Reset during the DOWN phase of a triangle.
      drive_cfg(1'b1, 100, 300, 100, 4);
      start = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         tick();
         if (k == 1) start = 1'b0;
         if (k == 13) chk("down_fcw", int'(fcw_out), 200);
      end
      sys_rst = 1'b1;
      tick();
      sys_rst = 1'b0;
      chk("mid_rst_fcw", int'(fcw_out), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_valid", int'(fcw_valid), 0);
      chk("mid_rst_done", int'(done), 0);
      tick();
      chk("mid_rst_idle", int'(busy), 0);
      chk("mid_rst_fcw2", int'(fcw_out), 0);
      run_vec(0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/fcw_sweep_ctrl.md
Name: fcw_sweep_ctrl

Overview:
- Upstream control stage for the NCO. It produces the 16-bit frequency control word (phase increment) that drives the NCO's phi_inc input.
- It replaces the fixed FCW parameter with a programmable stepped sweep: a single up-ramp, or a continuous triangle between two FCWs.
- Runs in the NCO clock domain (100 MHz PLL output). fcw_out connects directly to the NCO phase-increment input.

Parameters:
- FCW_W, 16, width of frequency control word (matches NCO phase accumulator; FCW = fout*2^FCW_W/fclk).
- DWELL_W, 24, width of the dwell-count input (cycles each FCW is held).

Ports:
- sys_clk  in  1  NCO clock.
- sys_rst  in  1  synchronous reset, active-high.
- start  in  1  level-sampled; starts a sweep when idle.
- abort  in  1  stops the sweep; wins over start.
- mode  in  1  0 = single up-sweep then done; 1 = continuous triangle.
- fcw_start  in  FCW_W  sweep low bound.
- fcw_stop  in  FCW_W  sweep high bound.
- fcw_step  in  FCW_W  increment per step; 0 is treated as 1.
- dwell  in  DWELL_W  cycles per FCW value; 0 is treated as 1.
- fcw_out  out  FCW_W  current FCW to the NCO.
- fcw_valid  out  1  one-cycle pulse each time fcw_out changes value/step.
- busy  out  1  high while a sweep is active.
- done  out  1  one-cycle pulse at normal sweep completion.

Behaviour:
- Reset (sync, any state): state=IDLE, fcw_out=0, fcw_valid=0, busy=0, done=0, dwell counter=0.
- States: IDLE, UP, DOWN.
- Configuration latching:
  - start is sampled at cycle T in IDLE.
  - mode, fcw_start, fcw_stop, fcw_step and dwell are latched at T.
  - Input changes during a sweep have no effect.
  - start while busy is ignored.
- Sweep start: at T+1, fcw_out=fcw_start, fcw_valid=1, busy=1, state=UP.
- Hold time: each value is held D=max(dwell,1) cycles. The next value appears D cycles after the previous one, so fcw_valid pulses are spaced exactly D apart.
- UP step: nxt = cur + S (S=max(step,1)), computed FCW_W+1 bits wide.
  - If the carry is set or nxt >= fcw_stop, output fcw_stop (clamp).
  - Once fcw_stop has been held D cycles:
    - mode 0: go to IDLE, busy=0 and done=1 in the same cycle.
    - mode 1: go to DOWN.
- DOWN step: nxt = cur - S.
  - If there is a borrow or nxt <= fcw_start, output fcw_start (clamp).
  - Once fcw_start has been held D cycles, go to UP. The sweep repeats until abort or reset.
- Degenerate bounds (fcw_stop <= fcw_start):
  - fcw_start is output once and held D cycles.
  - Then IDLE with done=1, in both modes.
- Abort (any non-IDLE state): the next cycle is IDLE with busy=0.
  - fcw_out holds its current value.
  - No done, no fcw_valid.
- Abort and start together in IDLE: abort wins; start is ignored.
- IDLE: fcw_out holds the last value (NCO keeps running at that frequency).
- Reset mid-sweep: identical to power-on reset; fcw_out=0.
- Dwell counter:
  - Loaded with D-1 on each fcw_valid, decremented to 0.
  - The step fires in the cycle after the counter reaches 0.
  - No arithmetic wraps; all compares are unsigned.

Decomposition:
- Shared package (sweep_pkg):
  - state enum {IDLE, UP, DOWN}.
  - FCW_W default constant, shared with the NCO wrapper.
  - mode encodings MODE_SINGLE=0, MODE_TRI=1.
- One sub-module: dwell_timer.
  - Ports: load, load value, expire pulse; DWELL_W wide.
  - Instantiated once.
- Next-FCW add/subtract and clamp stay inline in fcw_sweep_ctrl.

Test Plan:
- Single up-sweep, exact end.
  - Stimulus: mode=0, start=1000, stop=1400, step=100, dwell=4, start pulse at T.
  - Response: fcw_out = 1000/1100/1200/1300/1400 at T+1/T+5/T+9/T+13/T+17, fcw_valid high only in those cycles; done=1 and busy=0 at T+21.
- Overshoot clamp.
  - Stimulus: start=1000, stop=1250, step=100, dwell=2.
  - Response: sequence 1000, 1100, 1200, 1250; done at T+9.
- Triangle with carry clamp.
  - Stimulus: mode=1, start=100, stop=300, step=100, dwell=1.
  - Response: fcw_out 100, 200, 300, 200, 100, 200, ...; fcw_valid high every cycle; done never asserts.
  - Also: start=65000, stop=65535, step=1000 gives 65000 then 65535, no wrap to small values.
- Zero/degenerate inputs.
  - Stimulus: step=0, dwell=0, start=10, stop=13.
  - Response: 10, 11, 12, 13 on consecutive cycles.
  - Stimulus: stop=5, start=10.
  - Response: 10 held 1 cycle, then done.
- Abort and re-start.
  - Stimulus: abort asserted during the 1200 dwell of scenario 1; start asserted while busy.
  - Response: busy=0 next cycle, fcw_out stays 1200, no done; start-while-busy changes nothing.
  - Stimulus: start and abort together in IDLE.
  - Response: remains IDLE.
- Reset mid-operation.
  - Stimulus: sys_rst=1 for 1 cycle during the DOWN phase of triangle mode.
  - Response: the cycle after reset has fcw_out=0, busy=0, fcw_valid=0, done=0, state IDLE; a new start then behaves as in scenario 1.
